rep_sequencer_wb: RTL and testbench

Parametrised writeback-stage sequencer for REP/REPE/REPNE string instructions and HLT, replacing the fixed REPNE-CMPS-only termination logic. It tracks the repeat state across iterations and evaluates termination on each iteration's last uop. It gates the EIP load (hold for re-execute, load to advance), saves the first-uop pointer, counts completed iterations, and latches halt. It sits beside the flags/validate logic in WB and drives the fetch-redirect path.

---
 rtl/wb_pkg.sv | 21 ++
 rtl/count_zero_detect.sv | 19 +
 rtl/rep_sequencer_wb.sv | 142 ++++++++++++++
 tb/tb_rep_sequencer_wb.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared writeback-stage definitions: REP prefix encodings, sequencer states
// and default flag bit positions.
package wb_pkg;

    typedef enum logic [1:0] {
        REP_NONE = 2'b00,
        REP      = 2'b01,
        REPE     = 2'b10,
        REPNE    = 2'b11
    } rep_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_HALTED = 2'b10
    } wb_state_e;

    localparam int unsigned ZF_BIT_DEFAULT = 6;
    localparam int unsigned CF_BIT_DEFAULT = 0;

endpackage

// File: rtl/count_zero_detect.sv
// Zero compare on a string-op count; in 16-bit address mode only CX (the low
// 16 bits) is significant.
module count_zero_detect #(
    parameter int unsigned CNT_W = 32
) (
    input  logic [CNT_W-1:0] count_i,
    input  logic             addr16_i,
    output logic             zero_o
);

    if (CNT_W > 16) begin : g_wide
        assign zero_o = addr16_i ? (count_i[15:0] == 16'h0000) : (count_i == '0);
    end else begin : g_narrow
        logic unused_addr16;
        assign unused_addr16 = addr16_i;
        assign zero_o        = (count_i == '0);
    end

endmodule

// File: rtl/rep_sequencer_wb.sv
// Writeback-stage sequencer for REP/REPE/REPNE string instructions and HLT:
// gates the EIP load, counts iterations, saves the first-uop pointer, latches halt.
module rep_sequencer_wb
    import wb_pkg::*;
#(
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned FLAG_W = 32,
    parameter int unsigned ZF_BIT = ZF_BIT_DEFAULT
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              WB_V,
    input  logic              WB_FLUSH,
    input  logic              CS_IS_HALT_WB,
    input  logic              CS_LD_EIP_WB,
    input  logic [1:0]        REP_MODE,
    input  logic              IS_CMP,
    input  logic              ADDR16,
    input  logic              UOP_FIRST,
    input  logic              UOP_LAST,
    input  logic [CNT_W-1:0]  WB_COUNT_PRE,
    input  logic [CNT_W-1:0]  WB_COUNT_POST,
    input  logic [DATA_W-1:0] WB_RESULT_A,
    input  logic [FLAG_W-1:0] current_flags,
    output logic              v_ld_eip,
    output logic              rep_active,
    output logic              rep_again,
    output logic              rep_terminate,
    output logic              rep_skip,
    output logic [CNT_W-1:0]  iter_count,
    output logic [DATA_W-1:0] saved_ptr,
    output logic              wb_halt_all
);

    wb_state_e         state_q, state_d;
    logic              active_q;
    logic [CNT_W-1:0]  iter_q, iter_d, iter_base;
    logic [DATA_W-1:0] ptr_q, ptr_d;
    logic              halt_q, halt_d;

    logic      ld, again, term, skip;
    logic      pre_zero, post_zero, zf, stop, starting;
    rep_mode_e mode;

    count_zero_detect #(.CNT_W(CNT_W)) u_pre_zero (
        .count_i  (WB_COUNT_PRE),
        .addr16_i (ADDR16),
        .zero_o   (pre_zero)
    );

    count_zero_detect #(.CNT_W(CNT_W)) u_post_zero (
        .count_i  (WB_COUNT_POST),
        .addr16_i (ADDR16),
        .zero_o   (post_zero)
    );

    assign mode     = rep_mode_e'(REP_MODE);
    assign zf       = current_flags[ZF_BIT];
    assign starting = (state_q == ST_IDLE) && (mode != REP_NONE) && UOP_FIRST;
    assign stop     = post_zero
                    || ((mode == REPE)  && IS_CMP && !zf)
                    || ((mode == REPNE) && IS_CMP &&  zf);

    always_comb begin
        state_d   = state_q;
        iter_d    = iter_q;
        ptr_d     = ptr_q;
        halt_d    = halt_q;
        iter_base = iter_q;
        ld        = 1'b0;
        again     = 1'b0;
        term      = 1'b0;
        skip      = 1'b0;
        if (state_q == ST_HALTED) begin
            state_d = ST_HALTED;
        end else if (WB_FLUSH) begin
            state_d = ST_IDLE;
        end else if (WB_V) begin
            if (CS_IS_HALT_WB) begin
                state_d = ST_HALTED;
                halt_d  = 1'b1;
                ld      = CS_LD_EIP_WB;
            end else if (state_q == ST_IDLE && !starting) begin
                ld = CS_LD_EIP_WB;
            end else if (starting && pre_zero) begin
                skip   = 1'b1;
                term   = 1'b1;
                ld     = 1'b1;
                iter_d = '0;
            end else begin
                // A fresh instruction counts from zero; a single-uop iteration
                // both starts and evaluates in this same cycle.
                if (starting) begin
                    iter_base = '0;
                end
                iter_d  = iter_base;
                state_d = ST_ACTIVE;
                if (UOP_FIRST) begin
                    ptr_d = WB_RESULT_A;
                end
                if (UOP_LAST) begin
                    iter_d = (&iter_base) ? iter_base : iter_base + CNT_W'(1);
                    if (stop) begin
                        term    = 1'b1;
                        ld      = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        again = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!CLR) begin
            state_q  <= ST_IDLE;
            active_q <= 1'b0;
            iter_q   <= '0;
            ptr_q    <= '0;
            halt_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= (state_d == ST_ACTIVE);
            iter_q   <= iter_d;
            ptr_q    <= ptr_d;
            halt_q   <= halt_d;
        end
    end

    // Reset has top priority, so the combinational strobes are suppressed while CLR is low.
    assign v_ld_eip      = CLR & ld;
    assign rep_again     = CLR & again;
    assign rep_terminate = CLR & term;
    assign rep_skip      = CLR & skip;
    assign rep_active    = active_q;
    assign iter_count    = iter_q;
    assign saved_ptr     = ptr_q;
    assign wb_halt_all   = halt_q;

endmodule

// File: tb/tb_rep_sequencer_wb.sv
// Directed bench for rep_sequencer_wb with a per-cycle behavioural model.
module tb_rep_sequencer_wb;

    logic        clk = 1'b0;
    logic        CLR, WB_V, WB_FLUSH, CS_IS_HALT_WB, CS_LD_EIP_WB;
    logic [1:0]  REP_MODE;
    logic        IS_CMP, ADDR16, UOP_FIRST, UOP_LAST;
    logic [31:0] WB_COUNT_PRE, WB_COUNT_POST, WB_RESULT_A, current_flags;
    logic        v_ld_eip, rep_active, rep_again, rep_terminate, rep_skip, wb_halt_all;
    logic [31:0] iter_count, saved_ptr;

    int n_cmp = 0;
    int n_bad = 0;
    bit go = 1'b0;

    always #5 clk = ~clk;

    rep_sequencer_wb #(.CNT_W(32), .DATA_W(32), .FLAG_W(32), .ZF_BIT(6)) dut (
        .CLK(clk), .CLR(CLR), .WB_V(WB_V), .WB_FLUSH(WB_FLUSH),
        .CS_IS_HALT_WB(CS_IS_HALT_WB), .CS_LD_EIP_WB(CS_LD_EIP_WB),
        .REP_MODE(REP_MODE), .IS_CMP(IS_CMP), .ADDR16(ADDR16),
        .UOP_FIRST(UOP_FIRST), .UOP_LAST(UOP_LAST),
        .WB_COUNT_PRE(WB_COUNT_PRE), .WB_COUNT_POST(WB_COUNT_POST),
        .WB_RESULT_A(WB_RESULT_A), .current_flags(current_flags),
        .v_ld_eip(v_ld_eip), .rep_active(rep_active), .rep_again(rep_again),
        .rep_terminate(rep_terminate), .rep_skip(rep_skip),
        .iter_count(iter_count), .saved_ptr(saved_ptr), .wb_halt_all(wb_halt_all)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: iteration bookkeeping in plain integers.
    bit     m_active = 0, m_halt = 0;
    longint m_iters = 0, m_ptr = 0;
    localparam longint MAXC = 64'hFFFF_FFFF;

    function automatic longint eff(input logic [31:0] c, input logic a16);
        return a16 ? longint'(c % 32'h10000) : longint'(c);
    endfunction

    initial begin
        bit     e_ld, e_again, e_term, e_skip, n_active, n_halt, starting, zf, done;
        longint n_iters, n_ptr;
        forever begin
            @(negedge clk);
            e_ld = 0; e_again = 0; e_term = 0; e_skip = 0;
            n_active = m_active; n_halt = m_halt; n_iters = m_iters; n_ptr = m_ptr;
            zf = current_flags[6];
            if (!CLR) begin
                n_active = 0; n_halt = 0; n_iters = 0; n_ptr = 0;
            end else if (m_halt) begin
                n_halt = 1;
            end else if (WB_FLUSH) begin
                n_active = 0;
            end else if (WB_V) begin
                starting = !m_active && REP_MODE != 2'b00 && UOP_FIRST;
                if (CS_IS_HALT_WB) begin
                    n_halt = 1; n_active = 0; e_ld = CS_LD_EIP_WB;
                end else if (!m_active && !starting) begin
                    e_ld = CS_LD_EIP_WB;
                end else if (starting && eff(WB_COUNT_PRE, ADDR16) == 0) begin
                    e_skip = 1; e_term = 1; e_ld = 1; n_iters = 0;
                end else begin
                    if (starting) n_iters = 0;
                    if (UOP_FIRST) n_ptr = longint'(WB_RESULT_A);
                    n_active = 1;
                    if (UOP_LAST) begin
                        if (n_iters < MAXC) n_iters = n_iters + 1;
                        done = eff(WB_COUNT_POST, ADDR16) == 0
                            || (REP_MODE == 2'b10 && IS_CMP && !zf)
                            || (REP_MODE == 2'b11 && IS_CMP && zf);
                        e_term = done; e_again = !done; e_ld = done; n_active = !done;
                    end
                end
            end
            if (go) begin
                chk("v_ld_eip", longint'(v_ld_eip), longint'(e_ld));
                chk("rep_again", longint'(rep_again), longint'(e_again));
                chk("rep_terminate", longint'(rep_terminate), longint'(e_term));
                chk("rep_skip", longint'(rep_skip), longint'(e_skip));
                chk("rep_active", longint'(rep_active), longint'(m_active));
                chk("wb_halt_all", longint'(wb_halt_all), longint'(m_halt));
                chk("iter_count", longint'(iter_count), m_iters);
                chk("saved_ptr", longint'(saved_ptr), m_ptr);
            end
            @(posedge clk);
            m_active = n_active; m_halt = n_halt; m_iters = n_iters; m_ptr = n_ptr;
        end
    end

    task automatic drive(input bit v, input bit flush, input bit hlt, input bit ld,
                         input logic [1:0] mode, input bit cmp, input bit a16,
                         input bit first, input bit last, input logic [31:0] pre,
                         input logic [31:0] post, input logic [31:0] ptr, input bit zf);
        WB_V = v; WB_FLUSH = flush; CS_IS_HALT_WB = hlt; CS_LD_EIP_WB = ld;
        REP_MODE = mode; IS_CMP = cmp; ADDR16 = a16; UOP_FIRST = first; UOP_LAST = last;
        WB_COUNT_PRE = pre; WB_COUNT_POST = post; WB_RESULT_A = ptr;
        current_flags = zf ? 32'h0000_0041 : 32'h0000_0001;
        #2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
    endtask

    initial begin
        CLR = 1'b0;
        drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        step(); step();
        go = 1'b1;
        chk("reset_active", longint'(rep_active), 0);
        chk("reset_iter", longint'(iter_count), 0);
        chk("reset_halt", longint'(wb_halt_all), 0);
        CLR = 1'b1;

        // Plain uop passes its own EIP load through
        drive(1, 0, 0, 1, 2'b00, 0, 0, 1, 1, 0, 0, 32'h55, 0);
        chk("plain_ld", longint'(v_ld_eip), 1);
        step();
        idle();

        // REPNE CMPS, two uops per iteration, PRE=3
        drive(1, 0, 0, 1, 2'b11, 1, 0, 1, 0, 3, 2, 32'h1000, 0);
        chk("rn_first_ld", longint'(v_ld_eip), 0);
        step();
        chk("rn_ptr0", longint'(saved_ptr), 32'h1000);
        chk("rn_active", longint'(rep_active), 1);
        drive(1, 0, 0, 1, 2'b11, 1, 0, 0, 1, 3, 2, 32'h0, 0);
        chk("rn_again1", longint'(rep_again), 1);
        chk("rn_hold1", longint'(v_ld_eip), 0);
        step();
        drive(1, 0, 0, 1, 2'b11, 1, 0, 1, 0, 2, 1, 32'h1004, 0);
        step();
        chk("rn_ptr1", longint'(saved_ptr), 32'h1004);
        drive(1, 0, 0, 1, 2'b11, 1, 0, 0, 1, 2, 1, 32'h0, 0);
        chk("rn_again2", longint'(rep_again), 1);
        step();
        drive(1, 0, 0, 1, 2'b11, 1, 0, 1, 0, 1, 0, 32'h1008, 0);
        step();
        // WB_V low mid-repetition: nothing moves
        drive(0, 0, 0, 1, 2'b11, 1, 0, 0, 1, 1, 0, 32'h0, 1);
        step();
        drive(1, 0, 0, 1, 2'b11, 1, 0, 0, 1, 1, 5, 32'h0, 1);
        chk("rn_term", longint'(rep_terminate), 1);
        chk("rn_term_ld", longint'(v_ld_eip), 1);
        step();
        chk("rn_iters", longint'(iter_count), 3);
        chk("rn_idle", longint'(rep_active), 0);
        idle();

        // REP STOS single-uop, ZF=1 ignored
        drive(1, 0, 0, 1, 2'b01, 0, 0, 1, 1, 2, 1, 32'h2000, 1);
        chk("stos_again", longint'(rep_again), 1);
        chk("stos_hold", longint'(v_ld_eip), 0);
        step();
        drive(1, 0, 0, 1, 2'b01, 0, 0, 1, 1, 1, 0, 32'h2004, 1);
        chk("stos_term", longint'(rep_terminate), 1);
        chk("stos_ld", longint'(v_ld_eip), 1);
        step();
        chk("stos_iters", longint'(iter_count), 2);
        idle();

        // REPE CMPS with CX=0 (upper bits set): zero-count skip
        drive(1, 0, 0, 1, 2'b10, 1, 1, 1, 1, 32'h0001_0000, 32'h0000_FFFF, 32'h3000, 1);
        chk("skip", longint'(rep_skip), 1);
        chk("skip_term", longint'(rep_terminate), 1);
        chk("skip_ld", longint'(v_ld_eip), 1);
        step();
        chk("skip_iters", longint'(iter_count), 0);
        chk("skip_idle", longint'(rep_active), 0);
        idle();

        // REPE CMPS: ZF=0 ends early; POST masked to CX ends at zero
        drive(1, 0, 0, 1, 2'b10, 1, 0, 1, 1, 4, 3, 32'h4000, 0);
        chk("repe_zf0", longint'(rep_terminate), 1);
        step();
        drive(1, 0, 0, 1, 2'b10, 0, 0, 1, 1, 4, 3, 32'h4000, 0);
        chk("repe_nocmp", longint'(rep_again), 1);
        step();
        drive(1, 0, 0, 1, 2'b10, 1, 1, 1, 1, 32'h0002_0001, 32'h0002_0000, 32'h4004, 1);
        chk("a16_post", longint'(rep_terminate), 1);
        step();
        idle();

        // Flush together with the terminating uop
        drive(1, 0, 0, 1, 2'b01, 0, 0, 1, 1, 5, 4, 32'h5000, 0);
        step();
        drive(1, 1, 0, 1, 2'b01, 0, 0, 1, 1, 4, 0, 32'h5004, 0);
        chk("flush_term", longint'(rep_terminate), 0);
        chk("flush_ld", longint'(v_ld_eip), 0);
        step();
        chk("flush_active", longint'(rep_active), 0);
        chk("flush_iters", longint'(iter_count), 1);
        idle();

        // HLT mid-repetition, then ignored uops, then reset
        drive(1, 0, 0, 1, 2'b01, 0, 0, 1, 0, 5, 4, 32'h6000, 0);
        step();
        drive(1, 0, 1, 0, 2'b00, 0, 0, 1, 1, 0, 0, 32'h0, 0);
        step();
        chk("halt", longint'(wb_halt_all), 1);
        drive(1, 0, 0, 1, 2'b01, 0, 0, 1, 1, 1, 0, 32'h6004, 0);
        chk("halt_term", longint'(rep_terminate), 0);
        chk("halt_ld", longint'(v_ld_eip), 0);
        step();
        chk("halt_sticky", longint'(wb_halt_all), 1);
        idle();
        CLR = 1'b0;
        step();
        CLR = 1'b1;
        chk("clr_halt", longint'(wb_halt_all), 0);
        chk("clr_ptr", longint'(saved_ptr), 0);
        chk("clr_iters", longint'(iter_count), 0);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
